alu_scheduler: RTL and testbench
================================

# alu_scheduler

Sequencer and two-port arbiter in front of the shared 32-bit ALU. It accepts operation requests from two requesters: port 0 is the RISC-V core's execute stage and port 1 is the FFT engine. Grants are round-robin. The block drives the ALU's A/B/ctrl inputs from registered operands and returns a registered result. It also adds a multi-cycle MUL (low 32 bits) built from repeated ALU ADDs. It sits between the requesters and the ALU instance, which is external to this block.

## Interface
Parameters:
- `MUL_OP`, default 5'd10: op code that selects the shift-add multiply.

Ports (each requester port N is 0 or 1):
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `rN_valid`, in, 1: request N is valid.
- `rN_ready`, out, 1: request N is accepted this cycle.
- `rN_a`, in, 32: operand A.
- `rN_b`, in, 32: operand B.
- `rN_op`, in, 5: 0–9 use the ALU ctrl encoding; `MUL_OP` selects multiply; all other values are unsupported.
- `rN_rvalid`, out, 1: one-cycle response pulse for requester N.
- `rN_result`, out, 32: result, valid while `rN_rvalid` is high.
- `alu_a`, out, 32: ALU operand A.
- `alu_b`, out, 32: ALU operand B.
- `alu_ctrl`, out, 5: ALU ctrl.
- `alu_y`, in, 32: ALU result, combinational from `alu_a`/`alu_b`/`alu_ctrl`.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation
- States are IDLE, EXEC, MUL and RESP.
- Internal registers: `a_q`, `b_q`, `op_q`, `owner_q`, `res_q`, the round-robin pointer `ptr_q`, and the iteration counter `cnt_q` (6-bit).
- Grant logic is combinational and active only in IDLE:
  - Only one valid requester: that requester is granted.
  - Both valid: the requester `ptr_q` points to is granted.
  - `rN_ready` equals the grant for port N, so at most one ready is high per cycle.
  - A handshake is `rN_valid && rN_ready`.
- On a handshake:
  - Capture a/b/op into `a_q`/`b_q`/`op_q` and record `owner_q`.
  - Set `ptr_q` to the non-granted port.
  - Next state is MUL if op == `MUL_OP`, otherwise EXEC.
- EXEC (1 cycle):
  - Drive `alu_a`=`a_q`, `alu_b`=`b_q`, `alu_ctrl`=`op_q`.
  - `res_q` <= `alu_y` for op 0–9; `res_q` <= 0 for unsupported ops (11–31, excluding `MUL_OP`).
  - Next state is RESP.
- MUL (exactly 32 cycles, counted by `cnt_q` from 0 to 31):
  - `a_q` holds the multiplicand and `b_q` the multiplier; `res_q` is cleared to 0 on entry.
  - Each cycle: drive `alu_a`=`res_q`, `alu_b` = `b_q[0]` ? `a_q` : 0, `alu_ctrl`=0 (ADD).
  - Each cycle: `res_q` <= `alu_y`, `a_q` <= `a_q`<<1, `b_q` <= `b_q`>>1.
  - After `cnt_q`==31, go to RESP.
  - There is no early termination.
  - The result is the product mod 2^32, and the same value for signed and unsigned operands.
- RESP (1 cycle):
  - `r[owner_q]_rvalid`=1 and `r[owner_q]_result`=`res_q`.
  - Next state is IDLE.
  - Responses have no backpressure; the requester must sample the result in this cycle.
- Outside RESP, both `rN_rvalid` are 0 and both `rN_result` are 0.
- Outside EXEC/MUL, `alu_a`, `alu_b` and `alu_ctrl` are 0.
- Requester rules:
  - Hold a/b/op stable while valid and not ready.
  - Operands may change after the handshake cycle.
  - A requester may keep valid high after its handshake, which issues a new request.

## Timing
- After reset:
  - State is IDLE, `ptr_q`=0 (port 0 favoured), all registers are 0.
  - All outputs are 0, including both `rN_ready` while no valid is asserted.
- Simple op: handshake in cycle N, EXEC in N+1, rvalid in N+2, next handshake possible in N+3. Throughput is one op per 3 cycles.
- MUL: handshake in N, MUL in N+1..N+32, rvalid in N+33, next handshake possible in N+34.
- A request arriving while busy waits with `rN_ready`=0; there is no queueing beyond the requester holding valid.
- Both valid continuously: grants alternate 0,1,0,1…
- One port valid continuously: it receives every grant, and `ptr_q` keeps pointing at the other port.
- Reset mid-operation:
  - The transaction is dropped with no rvalid.
  - Next cycle is IDLE with `ptr_q`=0.
  - `rst` has priority over a handshake in the same cycle.
- Op values in the range 0–9 and the shift amount `b_q[4:0]` pass through unmodified to the ALU.

## Test plan
- After reset, r0 sends ADD a=5, b=7. Required: `r0_ready` in cycle N, `r0_rvalid`=1 with `r0_result`=12 in N+2 only, `r1_rvalid`=0 throughout.
- r0 and r1 valid in the same cycle after reset: r0 SUB 3−5, r1 SRA 0x80000000 by 4.
  - r0 is granted first and gets 0xFFFFFFFE.
  - r1 gets 0xF8000000, with its rvalid 3 cycles after r0's.
  - A third simultaneous pair is granted to r0.
- r1 sends MUL a=0xFFFFFFFD (−3), b=7. Required:
  - `busy` stays high for 33 cycles.
  - `r1_result`=0xFFFFFFEB in cycle N+33.
  - An r0 request raised at N+1 is accepted at N+34.
- Unsupported op 15 with a=b=0xFFFFFFFF: result 0 delivered at N+2.
- Check ALU idle outputs and ALU pass-through:
  - Outside EXEC/MUL, `alu_a`, `alu_b` and `alu_ctrl` must be 0.
  - An SLTU 1 < 0xFFFFFFFF request must return 1.
- Assert `rst` at MUL cycle 10. Required:
  - No rvalid follows.
  - `busy`=0 in the next cycle.
  - With both ports valid afterwards, the first grant goes to r0.

Source files
------------

// File: rtl/alu_scheduler_if.sv
// Bundle of the two requester ports and the shared-ALU port of alu_scheduler.
// The slave view belongs to the scheduler. The master view belongs to whoever
// drives requests and models the ALU.
interface alu_scheduler_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic [4:0]  r0_op;
  logic        r0_rvalid;
  logic [31:0] r0_result;

  logic        r1_valid;
  logic        r1_ready;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic [4:0]  r1_op;
  logic        r1_rvalid;
  logic [31:0] r1_result;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_y;

  logic        busy;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op,
    output r0_ready, r0_rvalid, r0_result,
    input  r1_valid, r1_a, r1_b, r1_op,
    output r1_ready, r1_rvalid, r1_result,
    output alu_a, alu_b, alu_ctrl,
    input  alu_y,
    output busy
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_op,
    input  r0_ready, r0_rvalid, r0_result,
    output r1_valid, r1_a, r1_b, r1_op,
    input  r1_ready, r1_rvalid, r1_result,
    input  alu_a, alu_b, alu_ctrl,
    output alu_y,
    input  busy
  );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin two-port front end for the shared 32-bit ALU.
// Ops 0-9 go to the ALU in a single EXEC cycle. The MUL op runs a 32-step
// shift-add loop that reuses the ALU as its adder.
module alu_scheduler #(
  parameter logic [4:0] MUL_OP = 5'd10
) (
  input logic            clk,
  input logic            rst,
  alu_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic [4:0]  op_q;
  logic        owner_q;
  logic        ptr_q;
  logic [5:0]  cnt_q;

  logic        grant0;
  logic        grant1;
  logic        hs;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [4:0]  sel_op;

  // Arbitration: only in IDLE; on contention the port named by ptr_q wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (bus.r0_valid && bus.r1_valid) begin
        grant0 = ~ptr_q;
        grant1 = ptr_q;
      end else begin
        grant0 = bus.r0_valid;
        grant1 = bus.r1_valid;
      end
    end
  end

  // A grant always implies the granted port is valid, so any grant is a handshake.
  assign hs     = grant0 | grant1;
  assign sel_a  = grant1 ? bus.r1_a  : bus.r0_a;
  assign sel_b  = grant1 ? bus.r1_b  : bus.r0_b;
  assign sel_op = grant1 ? bus.r1_op : bus.r0_op;

  assign bus.r0_ready = grant0;
  assign bus.r1_ready = grant1;
  assign bus.busy     = (state_q != IDLE);

  // Next-state logic plus ALU drive and response outputs, all zero by default.
  always_comb begin
    state_d       = state_q;
    bus.alu_a     = 32'd0;
    bus.alu_b     = 32'd0;
    bus.alu_ctrl  = 5'd0;
    bus.r0_rvalid = 1'b0;
    bus.r1_rvalid = 1'b0;
    bus.r0_result = 32'd0;
    bus.r1_result = 32'd0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = (sel_op == MUL_OP) ? MUL : EXEC;
        end
      end
      EXEC: begin
        bus.alu_a    = a_q;
        bus.alu_b    = b_q;
        bus.alu_ctrl = op_q;
        state_d      = RESP;
      end
      MUL: begin
        // Accumulate the partial product: res += b[0] ? a : 0, using ALU ADD.
        bus.alu_a    = res_q;
        bus.alu_b    = b_q[0] ? a_q : 32'd0;
        bus.alu_ctrl = 5'd0;
        if (cnt_q == 6'd31) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (owner_q) begin
          bus.r1_rvalid = 1'b1;
          bus.r1_result = res_q;
        end else begin
          bus.r0_rvalid = 1'b1;
          bus.r0_result = res_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and datapath: capture on handshake, compute in EXEC/MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
      op_q    <= 5'd0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (hs) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            owner_q <= grant1;
            // Favour the port that was not just served.
            ptr_q   <= grant0;
            res_q   <= 32'd0;
            cnt_q   <= 6'd0;
          end
        end
        EXEC: begin
          res_q <= (op_q <= 5'd9) ? bus.alu_y : 32'd0;
        end
        MUL: begin
          res_q <= bus.alu_y;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 6'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler. A transaction-level model predicts every output on
// every cycle. Directed cases pin the model to literal values, and a
// randomized phase follows.
module tb_alu_scheduler;
  localparam logic [4:0] MUL_OP = 5'd10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   check_en = 1'b0;

  alu_scheduler_if bus ();

  alu_scheduler #(.MUL_OP(MUL_OP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU ctrl encoding used by the external ALU.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op);
    logic [31:0] r;
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = a << b[4:0];
      5'd6: r = a >> b[4:0];
      5'd7: r = $signed(a) >>> b[4:0];
      5'd8: r = {31'd0, $signed(a) < $signed(b)};
      5'd9: r = {31'd0, a < b};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] op);
    logic [31:0] r;
    if (op == MUL_OP) r = a * b;
    else if (op <= 5'd9) r = alu_fn(a, b, op);
    else r = 32'd0;
    return r;
  endfunction

  // External ALU.
  always_comb bus.alu_y = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_left counts cycles until the scheduler is idle again: 0 means idle, and
  // 1 means the response cycle.
  int          m_left = 0;
  bit          m_ptr = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_mul = 1'b0;
  logic [31:0] m_a, m_b, m_res;
  logic [4:0]  m_op;
  logic        e_r0, e_r1;
  logic [31:0] e_aa, e_ab;
  logic [4:0]  e_ac;
  logic [31:0] mmask;
  int          mi;

  always @(negedge clk) begin
    if (check_en) begin
      e_r0 = (m_left == 0) && bus.r0_valid && (!bus.r1_valid || m_ptr == 1'b0);
      e_r1 = (m_left == 0) && bus.r1_valid && (!bus.r0_valid || m_ptr == 1'b1);
      e_aa = 32'd0;
      e_ab = 32'd0;
      e_ac = 5'd0;
      if (m_left >= 2 && m_mul) begin
        mi    = 33 - m_left;
        mmask = (32'd1 << mi) - 32'd1;
        e_aa  = m_a * (m_b & mmask);
        e_ab  = m_b[mi] ? (m_a << mi) : 32'd0;
      end else if (m_left == 2) begin
        e_aa = m_a;
        e_ab = m_b;
        e_ac = m_op;
      end
      check("r0_ready", {31'd0, bus.r0_ready}, {31'd0, e_r0});
      check("r1_ready", {31'd0, bus.r1_ready}, {31'd0, e_r1});
      check("busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
      check("r0_rvalid", {31'd0, bus.r0_rvalid}, {31'd0, m_left == 1 && !m_owner});
      check("r1_rvalid", {31'd0, bus.r1_rvalid}, {31'd0, m_left == 1 && m_owner});
      check("r0_result", bus.r0_result, (m_left == 1 && !m_owner) ? m_res : 32'd0);
      check("r1_result", bus.r1_result, (m_left == 1 && m_owner) ? m_res : 32'd0);
      check("alu_a", bus.alu_a, e_aa);
      check("alu_b", bus.alu_b, e_ab);
      check("alu_ctrl", {27'd0, bus.alu_ctrl}, {27'd0, e_ac});
      if (rst) begin
        m_left = 0;
        m_ptr  = 1'b0;
      end else begin
        if (m_left > 0) m_left--;
        if (e_r0 || e_r1) begin
          m_owner = e_r1;
          m_a     = e_r1 ? bus.r1_a  : bus.r0_a;
          m_b     = e_r1 ? bus.r1_b  : bus.r0_b;
          m_op    = e_r1 ? bus.r1_op : bus.r0_op;
          m_mul   = (m_op == MUL_OP);
          m_left  = m_mul ? 33 : 2;
          m_res   = exp_result(m_a, m_b, m_op);
          m_ptr   = ~e_r1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Raises each enabled port after its delay, drops valid after its handshake,
  // and runs until every enabled port has its response. Entered and left just
  // after a rising edge.
  task automatic run_pair(
    input bit en0, input int d0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] op0,
    input bit en1, input int d1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] op1,
    output int hs0, output int rv0, output logic [31:0] res0,
    output int hs1, output int rv1, output logic [31:0] res1);
    bit done;
    hs0 = -1; rv0 = -1; res0 = 32'd0;
    hs1 = -1; rv1 = -1; res1 = 32'd0;
    done = 1'b0;
    bus.r0_a = a0; bus.r0_b = b0; bus.r0_op = op0;
    bus.r1_a = a1; bus.r1_b = b1; bus.r1_op = op1;
    bus.r0_valid = en0 && (d0 == 0);
    bus.r1_valid = en1 && (d1 == 0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.r0_valid && bus.r0_ready) hs0 = cyc;
      if (bus.r1_valid && bus.r1_ready) hs1 = cyc;
      if (bus.r0_rvalid && rv0 < 0 && hs0 >= 0 && hs0 != cyc) begin
        rv0 = cyc; res0 = bus.r0_result;
      end
      if (bus.r1_rvalid && rv1 < 0 && hs1 >= 0 && hs1 != cyc) begin
        rv1 = cyc; res1 = bus.r1_result;
      end
      if ((!en0 || rv0 >= 0) && (!en1 || rv1 >= 0)) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      bus.r0_valid = en0 && (hs0 < 0) && (k + 1 >= d0);
      bus.r1_valid = en1 && (hs1 < 0) && (k + 1 >= d1);
    end
    check("pair_completed", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, rv0, hs1, rv1, seen, hs;
    logic [31:0] res0, res1;
    bit en0, en1;
    logic [31:0] a0, b0, a1, b1;
    logic [4:0] op0, op1;

    bus.r0_valid = 1'b0; bus.r0_a = 32'd0; bus.r0_b = 32'd0; bus.r0_op = 5'd0;
    bus.r1_valid = 1'b0; bus.r1_a = 32'd0; bus.r1_b = 32'd0; bus.r1_op = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;

    // Idle state right after reset.
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_r0_ready", {31'd0, bus.r0_ready}, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    @(posedge clk); #1;

    // ADD 5+7 on r0.
    run_pair(1, 0, 32'd5, 32'd7, 5'd0, 0, 0, 32'd0, 32'd0, 5'd0, hs0, rv0, res0, hs1, rv1, res1);
    check("add_result", res0, 32'd12);
    check("add_latency", rv0 - hs0, 32'd2);
    $display("txn add: hs=%0d rv=%0d res=0x%08h", hs0, rv0, res0);

    // Simultaneous SUB on r0 and SRA on r1 after reset.
    do_reset();
    run_pair(1, 0, 32'd3, 32'd5, 5'd1, 1, 0, 32'h8000_0000, 32'd4, 5'd7,
             hs0, rv0, res0, hs1, rv1, res1);
    check("sub_result", res0, 32'hFFFF_FFFE);
    check("sra_result", res1, 32'hF800_0000);
    check("pair_r0_first", {31'd0, hs0 < hs1}, 32'd1);
    check("pair_rvalid_gap", rv1 - rv0, 32'd3);
    $display("txn pair: r0 rv=%0d 0x%08h r1 rv=%0d 0x%08h", rv0, res0, rv1, res1);
    run_pair(1, 0, 32'd1, 32'd2, 5'd0, 1, 0, 32'd3, 32'd4, 5'd0,
             hs0, rv0, res0, hs1, rv1, res1);
    check("pair3_r0_first", {31'd0, hs0 < hs1}, 32'd1);
    $display("txn pair3: hs0=%0d hs1=%0d", hs0, hs1);

    // MUL -3*7 on r1; r0 raises a request one cycle later.
    run_pair(1, 1, 32'd100, 32'd23, 5'd0, 1, 0, 32'hFFFF_FFFD, 32'd7, MUL_OP,
             hs0, rv0, res0, hs1, rv1, res1);
    check("mul_result", res1, 32'hFFFF_FFEB);
    check("mul_latency", rv1 - hs1, 32'd33);
    check("mul_r0_wait", hs0 - hs1, 32'd34);
    check("mul_r0_result", res0, 32'd123);
    $display("txn mul: hs=%0d rv=%0d res=0x%08h r0 hs=%0d", hs1, rv1, res1, hs0);

    // Unsupported op 15.
    run_pair(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 0, 0, 32'd0, 32'd0, 5'd0,
             hs0, rv0, res0, hs1, rv1, res1);
    check("unsup_result", res0, 32'd0);
    check("unsup_latency", rv0 - hs0, 32'd2);
    $display("txn unsup: res=0x%08h", res0);

    // SLTU 1 < 0xFFFFFFFF on r1.
    run_pair(0, 0, 32'd0, 32'd0, 5'd0, 1, 0, 32'd1, 32'hFFFF_FFFF, 5'd9,
             hs0, rv0, res0, hs1, rv1, res1);
    check("sltu_result", res1, 32'd1);
    $display("txn sltu: res=0x%08h", res1);

    @(negedge clk);
    check("idle_alu_a", bus.alu_a, 32'd0);
    check("idle_alu_b", bus.alu_b, 32'd0);
    check("idle_alu_ctrl", {27'd0, bus.alu_ctrl}, 32'd0);
    @(posedge clk); #1;

    // Reset at MUL cycle 10 of an r0 multiply.
    bus.r0_a = 32'd12345; bus.r0_b = 32'd678; bus.r0_op = MUL_OP;
    bus.r0_valid = 1'b1;
    hs = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.r0_ready) begin
        hs = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check("rstmul_handshake", {31'd0, hs >= 0}, 32'd1);
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmul_busy", {31'd0, bus.busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.r0_rvalid || bus.r1_rvalid) seen++;
      @(negedge clk);
    end
    check("rstmul_no_rvalid", seen, 32'd0);
    @(posedge clk); #1;
    run_pair(1, 0, 32'd9, 32'd1, 5'd1, 1, 0, 32'd9, 32'd2, 5'd1,
             hs0, rv0, res0, hs1, rv1, res1);
    check("rstmul_r0_first", {31'd0, hs0 < hs1}, 32'd1);
    $display("txn reset-mid-mul: busy cleared, first grant hs0=%0d hs1=%0d", hs0, hs1);

    // Randomized requests.
    for (int it = 0; it < 150; it++) begin
      en0 = 1'($urandom_range(0, 1));
      en1 = 1'($urandom_range(0, 1));
      if (!en0 && !en1) en0 = 1'b1;
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      op0 = ($urandom_range(0, 9) < 6) ? 5'($urandom_range(0, 9))
          : (($urandom_range(0, 1) == 0) ? MUL_OP : 5'($urandom_range(11, 31)));
      op1 = ($urandom_range(0, 9) < 6) ? 5'($urandom_range(0, 9))
          : (($urandom_range(0, 1) == 0) ? MUL_OP : 5'($urandom_range(11, 31)));
      run_pair(en0, $urandom_range(0, 3), a0, b0, op0, en1, $urandom_range(0, 3), a1, b1, op1,
               hs0, rv0, res0, hs1, rv1, res1);
      if (en0) check("rand_r0_result", res0, exp_result(a0, b0, op0));
      if (en1) check("rand_r1_result", res1, exp_result(a1, b1, op1));
      $display("txn rand %0d: r0(%0d op%0d)=0x%08h r1(%0d op%0d)=0x%08h",
               it, en0, op0, res0, en1, op1, res1);
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
